// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and defaults for the byte-stream program loader
package program_loader_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_WORD_BYTES = 4;
  localparam int PROG_WORDS     = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, program memory write port out
interface program_loader_if #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4
) ();

  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    write;
  logic [ADDR_W-1:0]       addr_wr;
  logic [8*WORD_BYTES-1:0] data_in;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, write, addr_wr, data_in
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, write, addr_wr, data_in
  );

endinterface

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - MSB-first word shift register, byte counter and running XOR
module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    byte_en,
  input  logic [7:0]              byte_in,
  output logic [8*WORD_BYTES-1:0] word_next,
  output logic                    word_last,
  output logic [7:0]              csum
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [W-1:0]     word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;

  // New byte enters the LSB; the cast drops the oldest byte off the top.
  assign word_next = W'({word_q, byte_in});
  assign word_last = (cnt_q == CNT_W'(WORD_BYTES - 1));
  assign csum      = csum_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    csum_d = csum_q;
    if (clear) begin
      cnt_d  = '0;
      csum_d = '0;
    end else if (byte_en) begin
      word_d = word_next;
      csum_d = csum_q ^ byte_in;
      cnt_d  = word_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      csum_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      csum_q <= csum_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream bootloader driving the program memory write port
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  program_loader_if.slave   bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int W = 8 * WORD_BYTES;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              done_q, done_d, error_q, error_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [W-1:0]      data_in_q, data_in_d;
  logic [ADDR_W:0]   addr_cnt_q, addr_cnt_d, count_q, count_d, addr_next;
  logic              xfer, asm_clear, asm_byte_en, word_last;
  logic [W-1:0]      word_next;
  logic [7:0]        csum;

  assign busy         = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign cpu_hold     = busy;
  assign done         = done_q;
  assign error        = error_q;
  assign bus.rx_ready = busy;
  assign bus.write    = write_q;
  assign bus.addr_wr  = addr_wr_q;
  assign bus.data_in  = data_in_q;
  // abort outranks a byte offered on the same edge
  assign xfer         = bus.rx_valid && busy && !abort;
  assign addr_next    = addr_cnt_q + 1'b1;

  loader_word_assembler #(.WORD_BYTES(WORD_BYTES)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .byte_en   (asm_byte_en),
    .byte_in   (bus.rx_data),
    .word_next (word_next),
    .word_last (word_last),
    .csum      (csum)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    error_d     = error_q;
    write_d     = 1'b0;
    addr_wr_d   = addr_wr_q;
    data_in_d   = data_in_q;
    addr_cnt_d  = addr_cnt_q;
    count_d     = count_q;
    asm_clear   = 1'b0;
    asm_byte_en = 1'b0;
    if (abort && busy) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_LEN;
            done_d     = 1'b0;
            error_d    = 1'b0;
            addr_cnt_d = '0;
            asm_clear  = 1'b1;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            count_d = (bus.rx_data == 8'd0) ? FULL_COUNT : (ADDR_W+1)'(bus.rx_data);
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            asm_byte_en = 1'b1;
            if (word_last) begin
              write_d    = 1'b1;
              addr_wr_d  = addr_cnt_q[ADDR_W-1:0];
              data_in_d  = word_next;
              addr_cnt_d = addr_next;
              if (addr_next == count_q) state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            error_d = (bus.rx_data != csum);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_wr_q  <= '0;
      data_in_q  <= '0;
      addr_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      error_q    <= error_d;
      write_q    <= write_d;
      addr_wr_q  <= addr_wr_d;
      data_in_q  <= data_in_d;
      addr_cnt_q <= addr_cnt_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench with a frame-level reference model
module tb_program_loader;

  localparam int AW = 8;
  localparam int WB = 4;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, cpu_hold, done, error;
  int   total = 0;
  int   bad = 0;

  logic [31:0] mem [256];
  logic [39:0] wlog [$];

  program_loader_if #(.ADDR_W(AW), .WORD_BYTES(WB)) bus ();

  program_loader #(.ADDR_W(AW), .WORD_BYTES(WB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: tracks the frame as counts of bytes seen
  bit          m_active, m_write, m_done, m_err;
  int          m_n, m_bytes;
  logic [7:0]  m_xor, m_addr;
  logic [31:0] m_word, m_data;

  always @(posedge clk or negedge rst_n) begin
    int          nb;
    logic [31:0] nw;
    if (!rst_n) begin
      m_active <= 0; m_write <= 0; m_done <= 0; m_err <= 0;
      m_n <= -1; m_bytes <= 0; m_xor <= 0; m_addr <= 0; m_word <= 0; m_data <= 0;
    end else begin
      m_write <= 0;
      if (m_active && abort) begin
        m_active <= 0; m_done <= 0; m_err <= 0;
      end else if (!m_active && start) begin
        m_active <= 1; m_done <= 0; m_err <= 0;
        m_n <= -1; m_bytes <= 0; m_xor <= 0;
      end else if (m_active && bus.rx_valid) begin
        if (m_n < 0) begin
          m_n <= (bus.rx_data == 0) ? 256 : int'(bus.rx_data);
        end else if (m_bytes < m_n * WB) begin
          nb = m_bytes + 1;
          nw = {m_word[23:0], bus.rx_data};
          m_bytes <= nb;
          m_word  <= nw;
          m_xor   <= m_xor ^ bus.rx_data;
          if (nb % WB == 0) begin
            m_write <= 1;
            m_addr  <= 8'(nb / WB - 1);
            m_data  <= nw;
          end
        end else begin
          m_active <= 0; m_done <= 1; m_err <= (bus.rx_data != m_xor);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_ready", 64'(bus.rx_ready), 64'(m_active));
    chk("busy", 64'(busy), 64'(m_active));
    chk("cpu_hold", 64'(cpu_hold), 64'(m_active));
    chk("done", 64'(done), 64'(m_done));
    chk("error", 64'(error), 64'(m_err));
    chk("write", 64'(bus.write), 64'(m_write));
    chk("addr_wr", 64'(bus.addr_wr), 64'(m_addr));
    chk("data_in", 64'(bus.data_in), 64'(m_data));
    if (bus.write === 1'b1) wlog.push_back({bus.addr_wr, bus.data_in});
  end

  always @(posedge clk) if (bus.write === 1'b1) mem[bus.addr_wr] <= bus.data_in;

  function automatic logic [7:0] xor_of(input bq_t d);
    logic [7:0] x = 0;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  task automatic push(input logic [7:0] b, input int gap_pct, input bit noise);
    while (int'($urandom_range(99)) < gap_pct) begin
      bus.rx_valid = 0;
      bus.rx_data  = 8'($urandom);
      start = noise && ($urandom_range(3) == 0);
      @(negedge clk);
    end
    bus.rx_valid = 1;
    bus.rx_data  = b;
    start = noise && ($urandom_range(7) == 0);
    @(negedge clk);
    bus.rx_valid = 0;
    start = 0;
  endtask

  task automatic run_load(input bq_t d, input logic [7:0] n, input logic [7:0] c,
                          input int gap, input bit noise);
    wlog.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    push(n, gap, 0);
    foreach (d[i]) push(d[i], gap, noise);
    push(c, gap, 0);
    @(negedge clk);
  endtask

  task automatic check_words(input bq_t d, input string tag);
    int          nw;
    logic [31:0] w;
    nw = d.size() / WB;
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(nw));
    for (int k = 0; k < nw; k++) begin
      w = 0;
      for (int j = 0; j < WB; j++) w = (w << 8) | 32'(d[WB*k + j]);
      chk({tag, "_mem"}, 64'(mem[k]), 64'(w));
      if (k < wlog.size()) chk({tag, "_wlog"}, 64'(wlog[k]), 64'({8'(k), w}));
    end
  endtask

  initial begin
    bq_t         d;
    logic [39:0] ref_log [$];
    logic [31:0] prev1;
    bus.rx_valid = 0;
    bus.rx_data  = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(bus.rx_ready), 64'(0));
    chk("rst_write", 64'(bus.write), 64'(0));
    chk("rst_data", 64'(bus.data_in), 64'(0));
    rst_n = 1;
    @(negedge clk);

    // two words back-to-back, correct checksum 0x44
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(d, 8'd2, 8'h44, 0, 0);
    check_words(d, "t1");
    chk("t1_mem0", 64'(mem[0]), 64'h11223344);
    chk("t1_mem1", 64'(mem[1]), 64'hAABBCCDD);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_error", 64'(error), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));

    // N=0 means a full 256-word load
    d.delete();
    for (int i = 0; i < 1024; i++) d.push_back(8'($urandom));
    run_load(d, 8'd0, xor_of(d), 0, 0);
    check_words(d, "t2");
    chk("t2_nwrites_lit", 64'(wlog.size()), 64'(256));
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_error", 64'(error), 64'(0));

    // bad checksum; correct value would be 0x04
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(d, 8'd1, 8'h05, 0, 0);
    check_words(d, "t3");
    chk("t3_mem0", 64'(mem[0]), 64'h01020304);
    chk("t3_done", 64'(done), 64'(1));
    chk("t3_error", 64'(error), 64'(1));
    start = 1;
    @(negedge clk);
    start = 0;
    chk("t3_clr_done", 64'(done), 64'(0));
    chk("t3_clr_error", 64'(error), 64'(0));
    chk("t3_clr_busy", 64'(busy), 64'(1));
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t3_abort_busy", 64'(busy), 64'(0));

    // gap-free reference run, then gapped run with start noise
    d.delete();
    for (int i = 0; i < 48; i++) d.push_back(8'($urandom));
    run_load(d, 8'd12, xor_of(d), 0, 0);
    ref_log = wlog;
    run_load(d, 8'd12, xor_of(d), 40, 1);
    check_words(d, "t4");
    chk("t4_logsize", 64'(wlog.size()), 64'(ref_log.size()));
    for (int k = 0; k < ref_log.size() && k < wlog.size(); k++)
      chk("t4_same", 64'(wlog[k]), 64'(ref_log[k]));
    chk("t4_done", 64'(done), 64'(1));
    chk("t4_error", 64'(error), 64'(0));

    // abort after 6 of 8 data bytes, racing the 7th byte
    d = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78};
    prev1 = mem[1];
    wlog.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    push(8'd2, 0, 0);
    for (int i = 0; i < 6; i++) push(d[i], 0, 0);
    abort = 1;
    bus.rx_valid = 1;
    bus.rx_data  = d[6];
    @(negedge clk);
    abort = 0;
    bus.rx_valid = 0;
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    chk("t5_error", 64'(error), 64'(0));
    chk("t5_ready", 64'(bus.rx_ready), 64'(0));
    repeat (2) @(negedge clk);
    chk("t5_nwrites", 64'(wlog.size()), 64'(1));
    if (wlog.size() > 0) chk("t5_word0", 64'(wlog[0]), 64'({8'h00, 32'h5AC30FF0}));
    chk("t5_mem1_kept", 64'(mem[1]), 64'(prev1));

    // asynchronous reset in the middle of DATA
    start = 1;
    @(negedge clk);
    start = 0;
    push(8'd2, 0, 0);
    for (int i = 0; i < 3; i++) push(d[i], 0, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_hold", 64'(cpu_hold), 64'(0));
    chk("t6_ready", 64'(bus.rx_ready), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_addr", 64'(bus.addr_wr), 64'(0));
    chk("t6_data", 64'(bus.data_in), 64'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(d, 8'd2, 8'h44, 0, 0);
    check_words(d, "t6");
    chk("t6_final_done", 64'(done), 64'(1));
    chk("t6_final_error", 64'(error), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
